// File: rtl/data_sram_like_bridge.sv
// Bridges the single-cycle M-stage data port onto a handshaked SRAM-like bus.
// Stalls the pipeline until the access completes and holds load data until the M stage advances.
module data_sram_like_bridge #(
    parameter bit KSEG_MAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [3:0]  memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        longest_stall,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t      state_q, state_d;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q, rdata_d;

    logic        cur_wr;
    logic [1:0]  cur_size;
    logic [31:0] cur_paddr;
    logic [31:0] cur_addr;
    logic        is_idle;
    logic        launch;

    function automatic logic [1:0] store_size(input logic [3:0] be);
        logic [1:0] sz;
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = 2'd0;
            4'b0011, 4'b1100:                   sz = 2'd1;
            default:                            sz = 2'd2;
        endcase
        return sz;
    endfunction

    // kseg0/kseg1 are unmapped windows onto the low 512 MB.
    function automatic logic [31:0] phys_addr(input logic [31:0] va);
        logic [31:0] pa;
        if (KSEG_MAP && va[31:30] == 2'b10) begin
            pa = {3'b000, va[28:0]};
        end else begin
            pa = va;
        end
        return pa;
    endfunction

    always_comb begin
        cur_wr    = |memwrite;
        cur_paddr = phys_addr(addr);
        if (cur_wr) begin
            cur_size = store_size(memwrite);
            cur_addr = cur_paddr;
        end else begin
            // Loads always fetch the whole word; byte/half selection happens in W.
            cur_size = 2'd2;
            cur_addr = {cur_paddr[31:2], 2'b00};
        end
    end

    assign is_idle = (state_q == IDLE);
    assign launch  = is_idle & mem_en;

    assign data_req   = ~rst & (launch | (state_q == ADDR));
    assign stall_o    = ~rst & (launch | (state_q == ADDR) | (state_q == DATA));
    assign data_wr    = is_idle ? cur_wr   : wr_q;
    assign data_size  = is_idle ? cur_size : size_q;
    assign data_addr  = is_idle ? cur_addr : addr_q;
    assign data_wdata = is_idle ? wdata    : wdata_q;
    assign rdata_o    = rdata_q;

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (mem_en) begin
                    state_d = data_addr_ok ? DATA : ADDR;
                end
            end
            ADDR: begin
                if (data_addr_ok) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (data_data_ok) begin
                    state_d = DONE;
                    if (!wr_q) begin
                        rdata_d = data_rdata;
                    end
                end
            end
            DONE: begin
                // Held here while stalled elsewhere so the access is never reissued.
                if (!longest_stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // Request fields are captured once at issue and held until the access retires.
    always_ff @(posedge clk) begin
        if (launch) begin
            wr_q    <= cur_wr;
            size_q  <= cur_size;
            addr_q  <= cur_addr;
            wdata_q <= wdata;
        end
    end

endmodule
